bcd_time_counter: RTL and testbench

- Parametrised multi-digit BCD elapsed-time counter for the game timer and score-time displays.
- Contains its own tick prescaler, so it is driven directly from CLOCK_50.
- Counts up or down with correct same-cycle carry and borrow ripple across all digits.
- Supports clear, pause, parallel load, and wrap or saturate at the limits.
- Outputs packed BCD digits; these feed the existing hex_decoder instances one nibble per display.

---
 rtl/bcd_time_counter.sv | 93 +++++++++
 tb/tb_bcd_time_counter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: prescaled multi-digit BCD up/down elapsed-time counter with clear, pause, load and wrap/saturate
// Ports:
//   CLOCK_50    system clock, rising edge
//   resetn      asynchronous active-low reset
//   enable      1 = prescaler and counting run, 0 = everything holds
//   clear       synchronous clear of digits and prescaler (highest priority)
//   load        synchronous parallel load of load_value, nibbles clamped to 9
//   load_value  packed BCD load value, digit 0 in [3:0]
//   count_down  direction sampled on the tick cycle (1 = down)
//   digits      packed BCD count, digit 0 in [3:0]
//   tick        one-cycle pulse in the cycle the count has been updated by the prescaler
//   limit       one-cycle pulse with tick when the step wrapped or was held at a limit
//   is_zero     all digits are 0
module bcd_time_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000000,
    parameter bit WRAP       = 1'b1
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    count_down,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    tick,
    output logic                    limit,
    output logic                    is_zero
);
    localparam int W = 4 * NUM_DIGITS;
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          step;
    logic          hit;
    logic [W-1:0]  stepped;
    logic [W-1:0]  clamped;

    assign step    = enable && presc == PMAX;
    assign is_zero = digits == '0;

    // The carry/borrow ripples combinationally through every digit, so the
    // whole multi-digit step lands on a single edge. hit is the ripple out of
    // the top digit, i.e. the step crossed all-9s (up) or all-0s (down).
    always_comb begin
        logic       c;
        logic [3:0] d;
        c       = 1'b1;
        stepped = digits;
        clamped = load_value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = digits[4*i +: 4];
            if (count_down) begin
                stepped[4*i +: 4] = c ? (d == 4'd0 ? 4'd9 : d - 4'd1) : d;
                c = c && d == 4'd0;
            end else begin
                stepped[4*i +: 4] = c ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
                c = c && d == 4'd9;
            end
            clamped[4*i +: 4] = load_value[4*i +: 4] > 4'd9 ? 4'd9 : load_value[4*i +: 4];
        end
        hit = c;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            digits <= '0;
            presc  <= '0;
            tick   <= 1'b0;
            limit  <= 1'b0;
        end else if (clear) begin
            digits <= '0;
            presc  <= '0;
            tick   <= 1'b0;
            limit  <= 1'b0;
        end else if (load) begin
            digits <= clamped;
            presc  <= '0;
            tick   <= 1'b0;
            limit  <= 1'b0;
        end else begin
            tick  <= step;
            limit <= step && hit;
            if (enable)
                presc <= step ? '0 : presc + 1'b1;
            // In saturate mode a step at the limit leaves the digits untouched.
            if (step && (WRAP || !hit))
                digits <= stepped;
        end
    end
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: scoreboard bench for bcd_time_counter in wrap and saturate builds
module tb_bcd_time_counter;
    logic        CLOCK_50;
    logic        resetn;
    logic        enable;
    logic        clear;
    logic        load;
    logic [15:0] load_value;
    logic        count_down;
    logic [15:0] dig_w, dig_s;
    logic        tick_w, tick_s, lim_w, lim_s, zero_w, zero_s;

    bcd_time_counter #(.NUM_DIGITS(4), .TICK_DIV(4), .WRAP(1'b1)) dut_w (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .count_down(count_down), .digits(dig_w), .tick(tick_w),
        .limit(lim_w), .is_zero(zero_w)
    );

    bcd_time_counter #(.NUM_DIGITS(4), .TICK_DIV(4), .WRAP(1'b0)) dut_s (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .count_down(count_down), .digits(dig_s), .tick(tick_s),
        .limit(lim_s), .is_zero(zero_s)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [15:0] d;
        logic        t;
        logic        l;
        logic        z;
    } obs_t;

    obs_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_val[2];
    int   m_presc[2];
    bit   m_t[2];
    bit   m_l[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd_clamped(input logic [15:0] b);
        int v;
        int p;
        int n;
        v = 0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            n = int'(b[4*i +: 4]);
            v += (n > 9 ? 9 : n) * p;
            p *= 10;
        end
        return v;
    endfunction

    // Reference model in plain decimal integers; one call per clock edge,
    // pushing the expected post-edge outputs of both builds.
    task automatic model_edge();
        bit st;
        for (int i = 0; i < 2; i++) begin
            if (!resetn || clear) begin
                m_val[i] = 0; m_presc[i] = 0; m_t[i] = 0; m_l[i] = 0;
            end else if (load) begin
                m_val[i] = from_bcd_clamped(load_value); m_presc[i] = 0; m_t[i] = 0; m_l[i] = 0;
            end else begin
                st = enable && m_presc[i] == 3;
                m_t[i] = st;
                m_l[i] = 0;
                if (enable) m_presc[i] = st ? 0 : m_presc[i] + 1;
                if (st) begin
                    if (!count_down) begin
                        if (m_val[i] == 9999) begin
                            m_l[i] = 1;
                            if (i == 0) m_val[i] = 0;
                        end else m_val[i]++;
                    end else begin
                        if (m_val[i] == 0) begin
                            m_l[i] = 1;
                            if (i == 0) m_val[i] = 9999;
                        end else m_val[i]--;
                    end
                end
            end
            q.push_back('{d: to_bcd(m_val[i]), t: m_t[i], l: m_l[i], z: m_val[i] == 0});
        end
    endtask

    task automatic compare_out();
        obs_t  e;
        obs_t  g;
        string p;
        for (int i = 0; i < 2; i++) begin
            e = q.pop_front();
            g = i == 0 ? '{d: dig_w, t: tick_w, l: lim_w, z: zero_w} : '{d: dig_s, t: tick_s, l: lim_s, z: zero_s};
            p = i == 0 ? "wrap" : "sat";
            check({p, "_digits"}, 32'(g.d), 32'(e.d));
            check({p, "_tick"}, 32'(g.t), 32'(e.t));
            check({p, "_limit"}, 32'(g.l), 32'(e.l));
            check({p, "_is_zero"}, 32'(g.z), 32'(e.z));
        end
    endtask

    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            model_edge();
            @(posedge CLOCK_50);
            #1;
            compare_out();
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        load_value = v;
        cycle(1);
        load = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b1; clear = 1'b0; load = 1'b0;
        load_value = '0; count_down = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_val[i] = 0; m_presc[i] = 0; m_t[i] = 0; m_l[i] = 0;
        end
        #2;
        check("reset_digits", 32'(dig_w), 32'h0000);
        cycle(2);
        resetn = 1'b1;
        cycle(3);
        check("no_tick_before_4", 32'(tick_w), 32'h0);
        cycle(1);
        check("first_tick", 32'(tick_w), 32'h1);
        check("first_tick_digits", 32'(dig_w), 32'h0001);

        do_load(16'h0999);
        cycle(4);
        check("carry_ripple", 32'(dig_w), 32'h1000);

        do_load(16'h9999);
        cycle(4);
        check("wrap_up", 32'({dig_w, lim_w}), 32'({16'h0000, 1'b1}));
        check("sat_up", 32'({dig_s, lim_s}), 32'({16'h9999, 1'b1}));
        cycle(8);

        count_down = 1'b1;
        do_load(16'h1000);
        cycle(4);
        check("borrow_ripple", 32'(dig_w), 32'h0999);
        do_load(16'h0000);
        cycle(4);
        check("wrap_down", 32'({dig_w, lim_w}), 32'({16'h9999, 1'b1}));
        check("sat_down_zero", 32'({dig_s, zero_s}), 32'({16'h0000, 1'b1}));

        count_down = 1'b0;
        do_load(16'h0000);
        cycle(2);
        enable = 1'b0;
        cycle(10);
        enable = 1'b1;
        cycle(1);
        check("pause_no_early_tick", 32'(tick_w), 32'h0);
        cycle(1);
        check("pause_tick", 32'({dig_w, tick_w}), 32'({16'h0001, 1'b1}));

        cycle(3);
        clear = 1'b1; load = 1'b1; load_value = 16'h1234;
        cycle(1);
        clear = 1'b0; load = 1'b0;
        check("clear_over_load", 32'({dig_w, tick_w}), 32'({16'h0000, 1'b0}));

        do_load(16'hF3A7);
        check("load_clamp", 32'(dig_w), 32'h9397);

        for (int k = 0; k < 300; k++) begin
            enable = $urandom_range(0, 7) != 0;
            if ($urandom_range(0, 9) == 0) count_down = ~count_down;
            clear = $urandom_range(0, 59) == 0;
            load = $urandom_range(0, 19) == 0;
            load_value = $urandom_range(0, 3) == 0 ? 16'h9998 : ($urandom_range(0, 2) == 0 ? 16'h0001 : 16'($urandom));
            cycle(1);
        end
        clear = 1'b0; load = 1'b0; enable = 1'b1;

        do_load(16'h4321);
        cycle(2);
        #3;
        resetn = 1'b0;
        #1;
        check("async_reset_w", 32'(dig_w), 32'h0000);
        check("async_reset_s", 32'(dig_s), 32'h0000);
        cycle(2);
        resetn = 1'b1;
        cycle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
